// File: rtl/d_cache_axi_bridge.sv
// d_cache_axi_bridge: turns the data cache's req/addr_ok/data_ok miss and
// writeback port into single-beat AXI4 reads and writes, one at a time.
module d_cache_axi_bridge #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // cache side
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic                  bus_err,
  // AXI read address
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  // AXI read data
  input  logic [31:0]           rdata_axi,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  // AXI write address
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  // AXI write data
  output logic [31:0]           wdata_axi,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // AXI write response
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_B, S_DONE} state_t;

  state_t state_reg, state_next;
  logic err_reg, err_next;
  logic aw_done_reg, aw_done_next;
  logic w_done_reg, w_done_next;
  logic accept;
  logic [3:0] strb_calc;

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [1:0]  size_reg;
  logic [31:0] wdata_reg, rdata_reg;
  logic [3:0]  wstrb_reg;
  logic arvalid_reg, rready_reg, awvalid_reg, wvalid_reg, bready_reg;
  logic data_ok_reg, bus_err_reg;

  // Single-beat transfers only, so the last flag carries no information.
  logic rlast_unused;
  assign rlast_unused = rlast;

  assign accept  = req & (state_reg == S_IDLE);
  assign addr_ok = accept;

  assign araddr    = addr_reg;
  assign awaddr    = addr_reg;
  assign arsize    = {1'b0, size_reg};
  assign awsize    = {1'b0, size_reg};
  assign arlen     = 8'd0;
  assign awlen     = 8'd0;
  assign arburst   = 2'b01;
  assign awburst   = 2'b01;
  assign arvalid   = arvalid_reg;
  assign rready    = rready_reg;
  assign awvalid   = awvalid_reg;
  assign wvalid    = wvalid_reg;
  assign wlast     = wvalid_reg;
  assign bready    = bready_reg;
  assign wdata_axi = wdata_reg;
  assign wstrb     = wstrb_reg;
  assign rdata     = rdata_reg;
  assign data_ok   = data_ok_reg;
  assign bus_err   = bus_err_reg;

  // Byte-lane strobe from the incoming request; data is already lane-aligned.
  always_comb begin
    strb_calc = 4'b1111;
    case (size)
      2'd0:    strb_calc = 4'b0001 << addr[1:0];
      2'd1:    strb_calc = addr[1] ? 4'b1100 : 4'b0011;
      default: strb_calc = 4'b1111;
    endcase
  end

  // Next state, error flag and AW/W completion tracking.
  always_comb begin
    state_next   = state_reg;
    err_next     = err_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next   = wr ? S_AW : S_AR;
          err_next     = 1'b0;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end
      end
      S_AR: if (arvalid_reg && arready) state_next = S_R;
      S_R: begin
        if (rvalid && rready_reg) begin
          if (rresp != 2'b00) err_next = 1'b1;
          state_next = S_DONE;
        end
      end
      S_AW: begin
        if (awvalid_reg && awready) aw_done_next = 1'b1;
        if (wvalid_reg && wready)   w_done_next  = 1'b1;
        if (aw_done_next && w_done_next) state_next = S_B;
      end
      S_B: begin
        if (bvalid && bready_reg) begin
          if (bresp != 2'b00) err_next = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register and transaction bookkeeping flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      err_reg     <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      err_reg     <= err_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

  // Registered AXI handshakes, completion pulse and latched request fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      data_ok_reg <= 1'b0;
      bus_err_reg <= 1'b0;
      addr_reg    <= '0;
      size_reg    <= 2'd0;
      wdata_reg   <= 32'd0;
      wstrb_reg   <= 4'd0;
      rdata_reg   <= 32'd0;
    end else begin
      arvalid_reg <= (state_next == S_AR);
      rready_reg  <= (state_next == S_R);
      awvalid_reg <= (state_next == S_AW) && !aw_done_next;
      wvalid_reg  <= (state_next == S_AW) && !w_done_next;
      bready_reg  <= (state_next == S_B);
      data_ok_reg <= (state_next == S_DONE);
      bus_err_reg <= (state_next == S_DONE) && err_next;
      if (accept) begin
        addr_reg  <= addr;
        size_reg  <= size;
        wdata_reg <= wdata;
        wstrb_reg <= strb_calc;
      end
      if (state_reg == S_R && rvalid && rready_reg) rdata_reg <= rdata_axi;
    end
  end

endmodule

// File: tb/tb_d_cache_axi_bridge.sv
// Directed bench for d_cache_axi_bridge. Inputs change and outputs are
// sampled on the falling edge; "cycle N" counts from the accepting cycle.
module tb_d_cache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        addr_ok, data_ok, bus_err;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata_axi;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata_axi;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_cache_axi_bridge #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok), .bus_err(bus_err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request in the current cycle and confirm it is accepted.
  task automatic issue(input string tag, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; wr = w; size = s; addr = a; wdata = d;
    #1;
    chk({tag, ".addr_ok"}, {31'd0, addr_ok}, 32'd1);
    $display("REQ %s wr=%0d size=%0d addr=0x%08h wdata=0x%08h", tag, w, s, a, d);
    step();
    req = 1'b0;
  endtask

  // Zero-wait read, starting at the accept cycle, ending the cycle after data_ok.
  task automatic read0(input string tag, input logic [31:0] a, input logic [31:0] d);
    issue(tag, 1'b0, 2'd2, a, 32'd0);
    chk({tag, ".c1.arvalid"}, {31'd0, arvalid}, 32'd1);
    chk({tag, ".c1.araddr"}, araddr, a);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk({tag, ".c2.rready"}, {31'd0, rready}, 32'd1);
    rvalid = 1'b1; rdata_axi = d; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    chk({tag, ".c3.data_ok"}, {31'd0, data_ok}, 32'd1);
    chk({tag, ".c3.rdata"}, rdata, d);
    chk({tag, ".c3.bus_err"}, {31'd0, bus_err}, 32'd0);
    step();
    chk({tag, ".c4.data_ok"}, {31'd0, data_ok}, 32'd0);
    $display("DONE %s rdata=0x%08h", tag, rdata);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
    arready = 1'b0; rdata_axi = 32'd0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    step(); step();

    // Reset state
    chk("rst.valids", {25'd0, arvalid, rready, awvalid, wvalid, bready, data_ok, bus_err}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.araddr", araddr, 32'd0);
    chk("rst.awaddr", awaddr, 32'd0);
    chk("rst.wdata_axi", wdata_axi, 32'd0);
    chk("rst.wstrb", {28'd0, wstrb}, 32'd0);
    chk("rst.addr_ok", {31'd0, addr_ok}, 32'd0);
    $display("RESET checked");
    rst = 1'b0;
    step();

    // 1: zero-wait read with field checks
    issue("rd0", 1'b0, 2'd2, 32'h1000_0040, 32'd0);
    chk("rd0.c1.arvalid", {31'd0, arvalid}, 32'd1);
    chk("rd0.c1.araddr", araddr, 32'h1000_0040);
    chk("rd0.c1.arsize", {29'd0, arsize}, 32'd2);
    chk("rd0.c1.arlen", {24'd0, arlen}, 32'd0);
    chk("rd0.c1.arburst", {30'd0, arburst}, 32'd1);
    chk("rd0.c1.rready", {31'd0, rready}, 32'd0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("rd0.c2.arvalid", {31'd0, arvalid}, 32'd0);
    chk("rd0.c2.rready", {31'd0, rready}, 32'd1);
    chk("rd0.c2.data_ok", {31'd0, data_ok}, 32'd0);
    rvalid = 1'b1; rdata_axi = 32'hDEAD_BEEF;
    step();
    rvalid = 1'b0;
    chk("rd0.c3.data_ok", {31'd0, data_ok}, 32'd1);
    chk("rd0.c3.rdata", rdata, 32'hDEAD_BEEF);
    chk("rd0.c3.bus_err", {31'd0, bus_err}, 32'd0);
    chk("rd0.c3.rready", {31'd0, rready}, 32'd0);
    step();
    chk("rd0.c4.data_ok", {31'd0, data_ok}, 32'd0);
    chk("rd0.c4.rdata_hold", rdata, 32'hDEAD_BEEF);
    $display("DONE rd0 rdata=0x%08h", rdata);

    // 2: read with arready at cycle 4, rvalid at cycle 7 -> data_ok at cycle 8
    issue("rdst", 1'b0, 2'd2, 32'h2000_0010, 32'd0);
    for (int c = 1; c <= 8; c++) begin
      if (c <= 4) begin
        chk($sformatf("rdst.c%0d.arvalid", c), {31'd0, arvalid}, 32'd1);
        chk($sformatf("rdst.c%0d.araddr", c), araddr, 32'h2000_0010);
      end
      if (c == 2) begin
        req = 1'b1; wr = 1'b0; addr = 32'h2000_0099;
        #1;
        chk("rdst.c2.addr_ok_busy", {31'd0, addr_ok}, 32'd0);
      end
      if (c == 3) req = 1'b0;
      arready = (c == 4);
      if (c >= 5 && c <= 7) chk($sformatf("rdst.c%0d.rready", c), {31'd0, rready}, 32'd1);
      rvalid = (c == 7); rdata_axi = 32'h1234_5678;
      chk($sformatf("rdst.c%0d.data_ok", c), {31'd0, data_ok}, (c == 8) ? 32'd1 : 32'd0);
      step();
    end
    arready = 1'b0; rvalid = 1'b0;
    chk("rdst.rdata", rdata, 32'h1234_5678);
    $display("DONE rdst rdata=0x%08h", rdata);

    // 3: byte write, W accepted before AW
    issue("wrb", 1'b1, 2'd0, 32'h0000_0103, 32'hAB00_0000);
    chk("wrb.c1.awvalid", {31'd0, awvalid}, 32'd1);
    chk("wrb.c1.wvalid", {31'd0, wvalid}, 32'd1);
    chk("wrb.c1.wlast", {31'd0, wlast}, 32'd1);
    chk("wrb.c1.wstrb", {28'd0, wstrb}, 32'h8);
    chk("wrb.c1.wdata_axi", wdata_axi, 32'hAB00_0000);
    chk("wrb.c1.awaddr", awaddr, 32'h0000_0103);
    chk("wrb.c1.awsize", {29'd0, awsize}, 32'd0);
    chk("wrb.c1.arvalid", {31'd0, arvalid}, 32'd0);
    wready = 1'b1;
    step();
    wready = 1'b0;
    chk("wrb.c2.wvalid", {31'd0, wvalid}, 32'd0);
    chk("wrb.c2.awvalid", {31'd0, awvalid}, 32'd1);
    chk("wrb.c2.bready", {31'd0, bready}, 32'd0);
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("wrb.c3.awvalid", {31'd0, awvalid}, 32'd0);
    chk("wrb.c3.bready", {31'd0, bready}, 32'd1);
    chk("wrb.c3.data_ok", {31'd0, data_ok}, 32'd0);
    bvalid = 1'b1; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    chk("wrb.c4.data_ok", {31'd0, data_ok}, 32'd1);
    chk("wrb.c4.bus_err", {31'd0, bus_err}, 32'd0);
    step();
    chk("wrb.c5.data_ok", {31'd0, data_ok}, 32'd0);
    $display("DONE wrb");

    // 4: halfword write, simultaneous AW/W, SLVERR response
    issue("wrh", 1'b1, 2'd1, 32'h0000_0202, 32'h5A5A_0000);
    chk("wrh.c1.wstrb", {28'd0, wstrb}, 32'hC);
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    chk("wrh.c2.awvalid", {31'd0, awvalid}, 32'd0);
    chk("wrh.c2.wvalid", {31'd0, wvalid}, 32'd0);
    chk("wrh.c2.bready", {31'd0, bready}, 32'd1);
    bvalid = 1'b1; bresp = 2'b10;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    chk("wrh.c3.data_ok", {31'd0, data_ok}, 32'd1);
    chk("wrh.c3.bus_err", {31'd0, bus_err}, 32'd1);
    step();
    chk("wrh.c4.data_ok", {31'd0, data_ok}, 32'd0);
    chk("wrh.c4.bus_err", {31'd0, bus_err}, 32'd0);
    $display("DONE wrh bus_err pulse");

    // 5: reset while waiting in R
    issue("rrst", 1'b0, 2'd2, 32'h0000_0030, 32'd0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("rrst.c2.rready", {31'd0, rready}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rrst.c3.valids", {25'd0, arvalid, rready, awvalid, wvalid, bready, data_ok, bus_err}, 32'd0);
    chk("rrst.c3.araddr", araddr, 32'd0);
    chk("rrst.c3.rdata", rdata, 32'd0);
    $display("RESET mid-read checked");
    read0("rpost", 32'h0000_0044, 32'hCAFE_F00D);

    // 6: write, then a read held on req right behind it
    issue("b2bw", 1'b1, 2'd2, 32'h0000_0400, 32'h1122_3344);
    chk("b2bw.c1.wstrb", {28'd0, wstrb}, 32'hF);
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_0500;
    awready = 1'b1; wready = 1'b1;
    #1;
    chk("b2bw.c1.addr_ok", {31'd0, addr_ok}, 32'd0);
    step();
    awready = 1'b0; wready = 1'b0;
    chk("b2bw.c2.addr_ok", {31'd0, addr_ok}, 32'd0);
    chk("b2bw.c2.arvalid", {31'd0, arvalid}, 32'd0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("b2bw.c3.data_ok", {31'd0, data_ok}, 32'd1);
    chk("b2bw.c3.addr_ok", {31'd0, addr_ok}, 32'd0);
    step();
    chk("b2br.c4.addr_ok", {31'd0, addr_ok}, 32'd1);
    chk("b2br.c4.data_ok", {31'd0, data_ok}, 32'd0);
    step();
    req = 1'b0;
    chk("b2br.c5.arvalid", {31'd0, arvalid}, 32'd1);
    chk("b2br.c5.aw_w", {30'd0, awvalid, wvalid}, 32'd0);
    chk("b2br.c5.araddr", araddr, 32'h0000_0500);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("b2br.c6.rready", {31'd0, rready}, 32'd1);
    rvalid = 1'b1; rdata_axi = 32'h0BAD_F00D; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    chk("b2br.c7.data_ok", {31'd0, data_ok}, 32'd1);
    chk("b2br.c7.rdata", rdata, 32'h0BAD_F00D);
    $display("DONE b2b write+read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_cache_axi_bridge.md
# d_cache_axi_bridge

Converts the data cache's SRAM-like miss/writeback port (req / addr_ok / data_ok) into single-beat AXI4 read and write transactions. Sits directly below the data cache's `cache_data_*` interface and drives the AXI master port toward memory. One transaction is outstanding at a time. All AXI outputs and the response data are registered.

## Interface
- `ADDR_WIDTH`, default 32: address width on both sides. Data width is fixed at 32.
- `clk` in 1: single clock. All logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: cache request. Held high until `addr_ok`.
- `wr` in 1: 1 = write (writeback), 0 = read (refill).
- `size` in 2: 0 = byte, 1 = half, 2 = word.
- `addr` in ADDR_WIDTH: byte address.
- `wdata` in 32: write data, already lane-aligned.
- `rdata` out 32: read data, valid while `data_ok`.
- `addr_ok` out 1: request accepted (combinational).
- `data_ok` out 1: one-cycle completion pulse.
- `bus_err` out 1: pulses with `data_ok` when `rresp`/`bresp` ≠ OKAY.
- `araddr` out ADDR_WIDTH; `arlen` out 8; `arsize` out 3; `arburst` out 2; `arvalid` out 1; `arready` in 1.
- `rdata_axi` in 32; `rresp` in 2; `rlast` in 1; `rvalid` in 1; `rready` out 1.
- `awaddr` out ADDR_WIDTH; `awlen` out 8; `awsize` out 3; `awburst` out 2; `awvalid` out 1; `awready` in 1.
- `wdata_axi` out 32; `wstrb` out 4; `wlast` out 1; `wvalid` out 1; `wready` in 1.
- `bresp` in 2; `bvalid` in 1; `bready` out 1.

## Operation
- States: IDLE, AR, R, AW, B, DONE.
- `addr_ok = req & (state==IDLE)`. On accept, latch `addr`, `wr`, `size`, `wdata`. Next state is AW if `wr`, otherwise AR.
- AR: `arvalid`=1. On `arvalid & arready`, go to R.
- R: `rready`=1. On `rvalid & rready`, latch `rdata_axi` into `rdata` and set the error flag if `rresp`≠0. Go to DONE. `rlast` is ignored.
- AW: on entry, `awvalid` and `wvalid` are both 1.
  - Each drops on the cycle after its own handshake.
  - W may complete before, with, or after AW.
  - Go to B once both handshakes are done. Simultaneous completion goes to B on the same edge.
- B: `bready`=1. On `bvalid`, set the error flag if `bresp`≠0. Go to DONE.
- DONE: `data_ok`=1 and `bus_err`=error flag. `rdata` holds its value. Next state is IDLE. `addr_ok`=0 in DONE.
- AXI field values:
  - `arlen`/`awlen` = 0; `arburst`/`awburst` = 2'b01; `wlast` = 1 whenever `wvalid`.
  - `arsize`/`awsize` = {1'b0, latched size}.
  - `araddr`/`awaddr` = latched addr, unmodified.
- `wstrb` from latched size and addr[1:0]:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - size 2 or 3: 4'b1111.
- `wdata_axi` = latched wdata, not shifted.
- A `req` arriving in any state other than IDLE gets `addr_ok`=0 and is not latched. The cache keeps it held.
- Inputs `rvalid`/`bvalid` outside R/B are ignored. No ready is asserted, so the slave waits.

## Timing
- Reset values:
  - State IDLE.
  - `arvalid`, `rready`, `awvalid`, `wvalid`, `bready`, `data_ok`, `bus_err` = 0.
  - `rdata`, `araddr`, `awaddr`, `wdata_axi`, `wstrb` = 0. `addr_ok` is 0 because the state is IDLE.
- Read, zero-wait slave:
  - Accept at cycle 0.
  - `arvalid` at cycle 1, with `arready`.
  - `rready` at cycle 2, with `rvalid`.
  - `data_ok` at cycle 3.
  - Latency is 3 cycles plus slave stalls.
- Write, zero-wait slave:
  - Accept at cycle 0.
  - `awvalid`/`wvalid` at cycle 1.
  - `bready` at cycle 2.
  - `data_ok` at cycle 3.
- The earliest next accept is the cycle after DONE. Back-to-back throughput is one transaction per 4 cycles.
- `arvalid`/`awvalid`/`wvalid` never drop before their handshake. Address and data stay stable while valid.
- Reset asserted mid-transaction: every output returns to its reset value at the next edge and the in-flight transaction is abandoned. The whole system resets together. No `data_ok` is produced for the aborted request.

## Test plan
- Zero-wait read, addr 0x1000_0040, `rdata_axi`=0xDEAD_BEEF.
  - Required: `addr_ok` at cycle 0; `araddr`=0x1000_0040, `arsize`=3'b010, `arlen`=0; `data_ok`=1 with `rdata`=0xDEAD_BEEF exactly at cycle 3; `bus_err`=0.
- Read with `arready` delayed 3 cycles and `rvalid` delayed 2 cycles.
  - Required: `arvalid` and `araddr` stable throughout the stall; `data_ok` at cycle 8.
  - `req` re-raised during the stall gets `addr_ok`=0.
- Byte write at addr 0x0000_0103, wdata 0xAB00_0000, with `wready` before `awready`.
  - Required: `wstrb`=4'b1000, `wlast`=1; `wvalid` drops first; `bready` only after both handshakes; single `data_ok` pulse.
- Halfword write at 0x0000_0202 with `awready`/`wready` simultaneous and `bresp`=2'b10.
  - Required: `wstrb`=4'b1100; `data_ok` and `bus_err` both 1 for exactly one cycle.
- Reset pulsed while in R with `rvalid`=0.
  - Required: next cycle all AXI valids/readies=0, state IDLE, no `data_ok`.
  - A new read after reset completes normally.
- Back-to-back: a write followed immediately by a read held on `req`.
  - Required: the read's `addr_ok` fires the cycle after the write's `data_ok`; no overlap of AR with AW/W.
